// File: rtl/register_shadow_bank.sv
// register_shadow_bank
//   Double-buffered bank of configuration registers fed by the register
//   muxer's (index, value) stream. Writes land in a shadow copy and are
//   copied to the live bank only on frame_start, so the display never sees
//   a half-applied update. Registers flagged in IMMEDIATE_MASK bypass the
//   double buffer and update the live bank directly.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   register_index write index from the muxer; 0 means no write
//   register_value value paired with register_index
//   frame_start    one-cycle pulse at vertical blanking start; commits dirty entries
//   read_index     live-bank read address
//   read_value     live[read_index], registered (1-cycle latency)
//   dirty_mask     bit i set: shadow[i] holds an uncommitted write
//   commit_done    one-cycle pulse after a commit that copied at least one entry
//   write_count    accepted writes, modulo 256
module register_shadow_bank #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned VALUE_WIDTH = 23,
  parameter logic [(1 << INDEX_WIDTH)-1:0] IMMEDIATE_MASK = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INDEX_WIDTH-1:0]        register_index,
  input  logic [VALUE_WIDTH-1:0]        register_value,
  input  logic                          frame_start,
  input  logic [INDEX_WIDTH-1:0]        read_index,
  output logic [VALUE_WIDTH-1:0]        read_value,
  output logic [(1 << INDEX_WIDTH)-1:0] dirty_mask,
  output logic                          commit_done,
  output logic [7:0]                    write_count
);

  localparam int unsigned Depth = 1 << INDEX_WIDTH;

  logic [VALUE_WIDTH-1:0] shadow_q [Depth];
  logic [VALUE_WIDTH-1:0] shadow_d [Depth];
  logic [VALUE_WIDTH-1:0] live_q   [Depth];
  logic [VALUE_WIDTH-1:0] live_d   [Depth];
  logic [Depth-1:0]       dirty_q;
  logic [Depth-1:0]       dirty_d;
  logic                   write_en;

  // Index 0 is the muxer's idle slot, so entry 0 is never written.
  assign write_en   = (register_index != '0);
  assign dirty_mask = dirty_q;

  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    dirty_d  = dirty_q;

    // Commit copies the pre-edge shadow of every dirty entry.
    if (frame_start) begin
      for (int i = 0; i < Depth; i++) begin
        if (dirty_q[i]) begin
          live_d[i]  = shadow_q[i];
          dirty_d[i] = 1'b0;
        end
      end
    end

    // Applied after the commit so a same-cycle write to a normal register
    // re-marks it dirty and is deferred to the next frame.
    if (write_en) begin
      shadow_d[register_index] = register_value;
      if (IMMEDIATE_MASK[register_index]) begin
        live_d[register_index] = register_value;
      end else begin
        dirty_d[register_index] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      dirty_q     <= '0;
      read_value  <= '0;
      commit_done <= 1'b0;
      write_count <= 8'd0;
    end else begin
      shadow_q    <= shadow_d;
      live_q      <= live_d;
      dirty_q     <= dirty_d;
      read_value  <= live_q[read_index];
      commit_done <= frame_start & (|dirty_q);
      if (write_en) begin
        write_count <= write_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_register_shadow_bank.sv
module tb_register_shadow_bank;

  localparam logic [15:0] ImmMask = 16'h0002;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  register_index = '0;
  logic [22:0] register_value = '0;
  logic        frame_start = 1'b0;
  logic [3:0]  read_index = '0;
  logic [22:0] read_value;
  logic [15:0] dirty_mask;
  logic        commit_done;
  logic [7:0]  write_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  register_shadow_bank #(
    .INDEX_WIDTH   (4),
    .VALUE_WIDTH   (23),
    .IMMEDIATE_MASK(ImmMask)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .register_index(register_index),
    .register_value(register_value),
    .frame_start   (frame_start),
    .read_index    (read_index),
    .read_value    (read_value),
    .dirty_mask    (dirty_mask),
    .commit_done   (commit_done),
    .write_count   (write_count)
  );

  always #5 clk = ~clk;

  // Behavioural reference: two plain arrays plus a set of pending indices.
  int          m_shadow [16];
  int          m_live   [16];
  bit          m_pending[16];
  int          m_writes;
  int          m_read;
  bit          m_commit;

  function automatic logic [15:0] pending_bits();
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i] = m_pending[i];
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_shadow[i] = 0; m_live[i] = 0; m_pending[i] = 0;
      end
      m_writes = 0; m_read = 0; m_commit = 0;
    end else begin
      int  old_shadow [16];
      bit  any_pending;
      int  idx;
      old_shadow  = m_shadow;
      any_pending = 0;
      m_read = m_live[read_index];
      for (int i = 0; i < 16; i++) if (m_pending[i]) any_pending = 1;
      m_commit = frame_start && any_pending;
      if (frame_start) begin
        for (int i = 0; i < 16; i++) begin
          if (m_pending[i]) begin
            m_live[i] = old_shadow[i];
            m_pending[i] = 0;
          end
        end
      end
      idx = int'(register_index);
      if (idx != 0) begin
        m_shadow[idx] = int'(register_value);
        if (ImmMask[idx]) m_live[idx] = int'(register_value);
        else m_pending[idx] = 1;
        m_writes = m_writes + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model read_value", 32'(read_value), 32'(m_read));
      check("model dirty_mask", 32'(dirty_mask), 32'(pending_bits()));
      check("model commit_done", 32'(commit_done), 32'(m_commit));
      check("model write_count", 32'(write_count), 32'(m_writes % 256));
    end
  end

  // Drive at a negedge, return at the next negedge.
  task automatic tick(input logic [3:0] idx, input logic [22:0] val, input bit fs,
                      input logic [3:0] ridx);
    register_index = idx;
    register_value = val;
    frame_start    = fs;
    read_index     = ridx;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async rst read_value", 32'(read_value), 32'h0);
    check("async rst dirty_mask", 32'(dirty_mask), 32'h0);
    check("async rst commit_done", 32'(commit_done), 32'h0);
    check("async rst write_count", 32'(write_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [22:0] last_n;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("post reset read_value", 32'(read_value), 32'h0);
    check("post reset write_count", 32'(write_count), 32'h0);

    // Some writes, then an asynchronous reset between edges.
    tick(4'd2, 23'h5, 0, 0);
    tick(4'd2, 23'h6, 0, 0);
    tick(4'd2, 23'h6, 0, 0);
    check("dup writes counted", 32'(write_count), 32'd3);
    async_reset_pulse();
    tick(4'd0, 23'h0, 0, 4'd2);
    tick(4'd0, 23'h0, 0, 4'd2);
    check("reg2 cleared by reset", 32'(read_value), 32'h0);

    // Deferred write.
    tick(4'd3, 23'h12345, 0, 4'd3);
    check("deferred dirty", 32'(dirty_mask), 32'h0008);
    check("deferred live unchanged", 32'(read_value), 32'h0);
    tick(4'd0, 23'h0, 1, 4'd3);
    check("commit_done pulse", 32'(commit_done), 32'h1);
    check("dirty cleared", 32'(dirty_mask), 32'h0);
    tick(4'd0, 23'h0, 0, 4'd3);
    check("committed read", 32'(read_value), 32'h12345);
    check("commit_done one cycle", 32'(commit_done), 32'h0);

    // Same-cycle write and commit.
    tick(4'd5, 23'h00AA, 0, 4'd5);
    tick(4'd5, 23'h00BB, 1, 4'd5);
    check("conflict dirty5", 32'(dirty_mask[5]), 32'h1);
    tick(4'd0, 23'h0, 0, 4'd5);
    check("conflict live old", 32'(read_value), 32'h00AA);
    tick(4'd0, 23'h0, 1, 4'd5);
    tick(4'd0, 23'h0, 0, 4'd5);
    check("conflict live new", 32'(read_value), 32'h00BB);
    tick(4'd0, 23'h0, 1, 4'd5);
    check("empty commit no done", 32'(commit_done), 32'h0);

    // Immediate register.
    tick(4'd1, 23'h7FFFFF, 0, 4'd1);
    check("imm dirty", 32'(dirty_mask), 32'h0);
    check("imm no commit_done", 32'(commit_done), 32'h0);
    tick(4'd0, 23'h0, 0, 4'd1);
    check("imm read", 32'(read_value), 32'h7FFFFF);
    check("imm no commit_done 2", 32'(commit_done), 32'h0);

    // Muxed stream with counter wrap.
    async_reset_pulse();
    last_n = '0;
    for (int i = 0; i < 512; i++) begin
      if (i % 2 == 0) begin
        tick(4'd0, 23'($urandom), 0, 4'd7);
      end else begin
        last_n = 23'($urandom);
        tick(4'd7, last_n, 0, 4'd7);
      end
    end
    check("wrap write_count", 32'(write_count), 32'h0);
    check("stream dirty", 32'(dirty_mask), 32'h0080);
    tick(4'd0, 23'h0, 1, 4'd7);
    tick(4'd0, 23'h0, 0, 4'd7);
    check("stream last value", 32'(read_value), 32'(last_n));

    // Reset mid-stream while a commit is pending.
    for (int i = 4; i < 8; i++) tick(4'(i), 23'(i * 17), 0, 0);
    check("pre-reset dirty", 32'(dirty_mask), 32'h00F0);
    register_index = 4'd0;
    frame_start = 1'b1;
    #3 reset = 1'b1;
    #1;
    check("mid rst dirty", 32'(dirty_mask), 32'h0);
    @(negedge clk);
    check("mid rst commit_done", 32'(commit_done), 32'h0);
    reset = 1'b0;
    tick(4'd0, 23'h0, 0, 4'd4);
    check("no commit_done after release", 32'(commit_done), 32'h0);
    tick(4'd0, 23'h0, 1, 4'd4);
    check("no commit after release", 32'(commit_done), 32'h0);
    check("reg4 cleared", 32'(read_value), 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] idx;
      idx = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom);
      tick(idx, 23'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_shadow_bank.md
Name: register_shadow_bank

Overview:
- Consumes the time-multiplexed (index, value) register stream produced by the register muxer.
- Holds a 16-entry shadow copy of the video/terminal configuration registers.
- Commits the shadow copy to a live bank only at a frame boundary, so the display never sees a half-applied update.
- Provides a registered read port and dirty/commit status to the rest of the design.

Parameters:
- INDEX_WIDTH, 4, width of the register index; bank depth is 2**INDEX_WIDTH.
- VALUE_WIDTH, 23, width of each register value.
- IMMEDIATE_MASK, 16'h0000, bit i set means register i bypasses double buffering; a write reaches the live bank directly.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- register_index  input  INDEX_WIDTH  index from the muxer; 0 means no write
- register_value  input  VALUE_WIDTH  value paired with register_index
- frame_start  input  1  one-cycle pulse at the vertical blanking start; triggers commit
- read_index  input  INDEX_WIDTH  live-bank read address
- read_value  output  VALUE_WIDTH  live[read_index], registered
- dirty_mask  output  2**INDEX_WIDTH  bit i set means shadow[i] holds an uncommitted write; bit 0 is always 0
- commit_done  output  1  one-cycle pulse on the cycle after a commit that copied at least one entry
- write_count  output  8  number of accepted writes, wrapping modulo 256

Behaviour:
- Reset (async, active-high), applied in any state, including mid-commit:
  - all shadow and live entries = 0
  - read_value = 0, dirty_mask = 0, commit_done = 0, write_count = 0
- Write acceptance:
  - Each cycle with register_index != 0 is one write.
  - Index 0 is ignored, with no state change; this covers the muxer's reset output of 0/0.
- Normal register i (IMMEDIATE_MASK[i] = 0), on clk edge:
  - shadow[i] <= register_value
  - dirty_mask[i] <= 1
- Immediate register i (IMMEDIATE_MASK[i] = 1), on clk edge:
  - shadow[i] <= register_value and live[i] <= register_value
  - dirty_mask[i] stays 0
- Counting: every accepted write increments write_count by 1, wrapping 255 -> 0. Duplicate values are still counted.
- Commit: on a clk edge with frame_start = 1, for every i with dirty_mask[i] = 1:
  - live[i] <= shadow[i] (the pre-edge shadow value)
  - dirty_mask[i] <= 0
- Commit status: commit_done is 1 in the following cycle if the pre-edge dirty_mask was nonzero; otherwise it stays 0.
- Write in the same cycle as frame_start, to a normal register j:
  - The commit uses the old shadow[j].
  - The new value lands in shadow[j] and dirty_mask[j] ends at 1, so the write is deferred to the next frame.
  - Other dirty entries commit normally.
- Write in the same cycle as frame_start, to an immediate register: the live bank takes the incoming value. Immediate registers are never dirty, so there is no conflict.
- Consecutive frame_start pulses: each one is a separate commit; a second commit with nothing dirty produces no commit_done.
- Read port: read_value <= live[read_index] on each edge, so latency is 1 cycle.
  - The value read reflects live contents before that same edge's write/commit.
  - Index 0 reads live[0], which is always 0 because it is never written.
- Throughput: one write per cycle sustained, with no back-pressure. This matches the muxer's alternating output rate.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset asynchronously between edges; index stays 0.
  - Required: all outputs 0 immediately.
  - Required after release: read_value of any index = 0 and write_count = 0.
- Deferred write:
  - Stimulus: write index 3 = 23'h12345.
  - Required: dirty_mask = 16'h0008, and read_index 3 still returns 0.
  - Stimulus: pulse frame_start.
  - Required: commit_done = 1 for one cycle, dirty_mask = 0, and read_value = 23'h12345 one cycle after read_index = 3.
- Same-cycle conflict:
  - Setup: write index 5 = 23'h00AA; one cycle later, drive index 5 = 23'h00BB together with frame_start.
  - Required: live[5] = 23'h00AA and dirty_mask[5] = 1.
  - Stimulus: next frame_start.
  - Required: live[5] = 23'h00BB.
- Immediate register:
  - Setup: IMMEDIATE_MASK = 16'h0002; write index 1 = 23'h7FFFFF.
  - Required: read_value = 23'h7FFFFF with no frame_start, dirty_mask = 0, and commit_done never asserted.
- Muxed stream plus counter wrap:
  - Stimulus: alternate (0, x) and (7, n) for 512 cycles.
  - Required: write_count = 0 (256 writes, wrapped), dirty_mask = 16'h0080, and shadow[7] holds the last n.
- Reset mid-stream:
  - Stimulus: assert reset while dirty_mask = 16'h00F0 and frame_start is pulsing.
  - Required: everything clears, and no commit_done follows the release.
